// File: rtl/scaler_sequencer.sv
// scaler_sequencer
//   Configures one horizontal and one vertical frac_interp instance from the
//   source/destination dimensions, waits for both dividers to report ready,
//   then turns output video timing strobes into step_reset/step_in pulses and
//   interpolator step_out pulses into source fetch advance strobes.
//
// Ports
//   clk, reset_n                  clock, async active-low reset
//   src_w/src_h/dst_w/dst_h       source and destination active dimensions
//   reconfig                      strobe forcing a reconfiguration
//   frame_start/line_start/pix_ce output video timing strobes
//   h_*/v_* num/den/limit         registered interpolator configuration
//   h_/v_newfraction              one-cycle divider start pulses
//   h_/v_ready                    interpolator ready pulses
//   h_/v_step_reset, h_/v_step_in registered sequencing strobes
//   h_/v_step_out                 interpolator advance pulses
//   src_pix_adv/src_line_adv      registered source fetch strobes
//   running                       high while in RUN
//   cfg_error                     sticky, cleared on a successful configuration
module scaler_sequencer #(
  parameter int bitwidth = 10,
  parameter int timeout  = 1023
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [bitwidth-1:0] src_w,
  input  logic [bitwidth-1:0] src_h,
  input  logic [bitwidth-1:0] dst_w,
  input  logic [bitwidth-1:0] dst_h,
  input  logic                reconfig,
  input  logic                frame_start,
  input  logic                line_start,
  input  logic                pix_ce,
  output logic [bitwidth-1:0] h_num,
  output logic [bitwidth-1:0] h_den,
  output logic [bitwidth-1:0] h_limit,
  output logic [bitwidth-1:0] v_num,
  output logic [bitwidth-1:0] v_den,
  output logic [bitwidth-1:0] v_limit,
  output logic                h_newfraction,
  output logic                v_newfraction,
  input  logic                h_ready,
  input  logic                v_ready,
  output logic                h_step_reset,
  output logic                h_step_in,
  output logic                v_step_reset,
  output logic                v_step_in,
  input  logic                h_step_out,
  input  logic                v_step_out,
  output logic                src_pix_adv,
  output logic                src_line_adv,
  output logic                running,
  output logic                cfg_error
);

  localparam int TW = (timeout < 2) ? 1 : $clog2(timeout + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LOAD, S_WAIT, S_RUN, S_ERROR
  } state_t;

  typedef logic [bitwidth-1:0] dim_t;

  state_t        state_q, state_d;
  dim_t          sh_src_w_q, sh_src_w_d, sh_src_h_q, sh_src_h_d;
  dim_t          sh_dst_w_q, sh_dst_w_d, sh_dst_h_q, sh_dst_h_d;
  dim_t          h_num_q, h_num_d, h_den_q, h_den_d, h_limit_q, h_limit_d;
  dim_t          v_num_q, v_num_d, v_den_q, v_den_d, v_limit_q, v_limit_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          h_ok_q, h_ok_d, v_ok_q, v_ok_d;
  logic          first_line_q, first_line_d;
  logic          newfraction_q, newfraction_d;
  logic          h_step_reset_q, h_step_reset_d, h_step_in_q, h_step_in_d;
  logic          v_step_reset_q, v_step_reset_d, v_step_in_q, v_step_in_d;
  logic          src_pix_adv_q, src_pix_adv_d, src_line_adv_q, src_line_adv_d;
  logic          running_q, running_d, cfg_error_q, cfg_error_d;

  logic changed, bad_dims, h_seen, v_seen, first_now;

  always_comb begin
    changed  = reconfig || (src_w != sh_src_w_q) || (src_h != sh_src_h_q) ||
               (dst_w != sh_dst_w_q) || (dst_h != sh_dst_h_q);
    // Zero dimensions and downscaling are both rejected.
    bad_dims = (src_w == '0) || (src_h == '0) || (dst_w == '0) || (dst_h == '0) ||
               (dst_w < src_w) || (dst_h < src_h);
    // Ready inputs are pulses: fold this cycle's pulse into the sticky flag.
    h_seen    = h_ok_q | h_ready;
    v_seen    = v_ok_q | v_ready;
    // A frame_start in the same cycle makes this line the first one.
    first_now = first_line_q | frame_start;

    state_d        = state_q;
    sh_src_w_d     = sh_src_w_q;
    sh_src_h_d     = sh_src_h_q;
    sh_dst_w_d     = sh_dst_w_q;
    sh_dst_h_d     = sh_dst_h_q;
    h_num_d        = h_num_q;
    h_den_d        = h_den_q;
    h_limit_d      = h_limit_q;
    v_num_d        = v_num_q;
    v_den_d        = v_den_q;
    v_limit_d      = v_limit_q;
    cnt_d          = cnt_q;
    h_ok_d         = h_ok_q;
    v_ok_d         = v_ok_q;
    first_line_d   = first_line_q;
    newfraction_d  = 1'b0;
    h_step_reset_d = 1'b0;
    h_step_in_d    = 1'b0;
    v_step_reset_d = 1'b0;
    v_step_in_d    = 1'b0;
    src_pix_adv_d  = 1'b0;
    src_line_adv_d = 1'b0;
    cfg_error_d    = cfg_error_q;

    unique case (state_q)
      S_IDLE: state_d = S_CHECK;
      S_CHECK: begin
        sh_src_w_d = src_w;
        sh_src_h_d = src_h;
        sh_dst_w_d = dst_w;
        sh_dst_h_d = dst_h;
        if (bad_dims) begin
          state_d = S_ERROR;
        end else begin
          // Config registers take the values being latched into the shadow
          // registers now, so they are valid in the same cycle as newfraction.
          state_d       = S_LOAD;
          newfraction_d = 1'b1;
          h_num_d       = dst_w;
          h_den_d       = src_w;
          h_limit_d     = src_w - 1'b1;
          v_num_d       = dst_h;
          v_den_d       = src_h;
          v_limit_d     = src_h - 1'b1;
        end
      end
      S_LOAD: begin
        // Ready pulses during the newfraction cycle are deliberately ignored.
        h_ok_d  = 1'b0;
        v_ok_d  = 1'b0;
        cnt_d   = TW'(timeout);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        h_ok_d = h_seen;
        v_ok_d = v_seen;
        cnt_d  = cnt_q - 1'b1;
        if (h_seen && v_seen)       state_d = S_RUN;
        else if (cnt_q <= TW'(1))   state_d = S_ERROR;
      end
      S_RUN: begin
        v_step_reset_d = frame_start;
        h_step_reset_d = line_start;
        h_step_in_d    = pix_ce;
        src_pix_adv_d  = h_step_out;
        src_line_adv_d = v_step_out;
        if (line_start) begin
          v_step_in_d  = !first_now;
          first_line_d = 1'b0;
        end else if (frame_start) begin
          first_line_d = 1'b1;
        end
        if (changed) state_d = S_CHECK;
      end
      S_ERROR: if (changed) state_d = S_CHECK;
      default: state_d = S_IDLE;
    endcase

    running_d = (state_d == S_RUN);
    if (state_d == S_RUN)        cfg_error_d = 1'b0;
    else if (state_d == S_ERROR) cfg_error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      sh_src_w_q     <= '0;
      sh_src_h_q     <= '0;
      sh_dst_w_q     <= '0;
      sh_dst_h_q     <= '0;
      h_num_q        <= dim_t'(1);
      h_den_q        <= dim_t'(1);
      h_limit_q      <= '0;
      v_num_q        <= dim_t'(1);
      v_den_q        <= dim_t'(1);
      v_limit_q      <= '0;
      cnt_q          <= '0;
      h_ok_q         <= 1'b0;
      v_ok_q         <= 1'b0;
      first_line_q   <= 1'b0;
      newfraction_q  <= 1'b0;
      h_step_reset_q <= 1'b0;
      h_step_in_q    <= 1'b0;
      v_step_reset_q <= 1'b0;
      v_step_in_q    <= 1'b0;
      src_pix_adv_q  <= 1'b0;
      src_line_adv_q <= 1'b0;
      running_q      <= 1'b0;
      cfg_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sh_src_w_q     <= sh_src_w_d;
      sh_src_h_q     <= sh_src_h_d;
      sh_dst_w_q     <= sh_dst_w_d;
      sh_dst_h_q     <= sh_dst_h_d;
      h_num_q        <= h_num_d;
      h_den_q        <= h_den_d;
      h_limit_q      <= h_limit_d;
      v_num_q        <= v_num_d;
      v_den_q        <= v_den_d;
      v_limit_q      <= v_limit_d;
      cnt_q          <= cnt_d;
      h_ok_q         <= h_ok_d;
      v_ok_q         <= v_ok_d;
      first_line_q   <= first_line_d;
      newfraction_q  <= newfraction_d;
      h_step_reset_q <= h_step_reset_d;
      h_step_in_q    <= h_step_in_d;
      v_step_reset_q <= v_step_reset_d;
      v_step_in_q    <= v_step_in_d;
      src_pix_adv_q  <= src_pix_adv_d;
      src_line_adv_q <= src_line_adv_d;
      running_q      <= running_d;
      cfg_error_q    <= cfg_error_d;
    end
  end

  assign h_num         = h_num_q;
  assign h_den         = h_den_q;
  assign h_limit       = h_limit_q;
  assign v_num         = v_num_q;
  assign v_den         = v_den_q;
  assign v_limit       = v_limit_q;
  assign h_newfraction = newfraction_q;
  assign v_newfraction = newfraction_q;
  assign h_step_reset  = h_step_reset_q;
  assign h_step_in     = h_step_in_q;
  assign v_step_reset  = v_step_reset_q;
  assign v_step_in     = v_step_in_q;
  assign src_pix_adv   = src_pix_adv_q;
  assign src_line_adv  = src_line_adv_q;
  assign running       = running_q;
  assign cfg_error     = cfg_error_q;

endmodule

// File: tb/tb_scaler_sequencer.sv
module tb_scaler_sequencer;
  localparam int BW = 10;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [BW-1:0] src_w, src_h, dst_w, dst_h;
  logic reconfig, frame_start, line_start, pix_ce;
  logic h_ready, v_ready, h_step_out, v_step_out;
  logic [BW-1:0] h_num, h_den, h_limit, v_num, v_den, v_limit;
  logic h_newfraction, v_newfraction;
  logic h_step_reset, h_step_in, v_step_reset, v_step_in;
  logic src_pix_adv, src_line_adv, running, cfg_error;

  int n_cmp = 0;
  int n_bad = 0;
  int lines_in_frame = 0;
  int t_vsr, t_hsr, t_vsi, t_hsi, t_pix, t_line;
  int run_at, err_at, ha, va;
  logic [BW-1:0] held_num;

  always #5 clk = ~clk;

  scaler_sequencer #(.bitwidth(BW), .timeout(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
    .reconfig(reconfig), .frame_start(frame_start), .line_start(line_start), .pix_ce(pix_ce),
    .h_num(h_num), .h_den(h_den), .h_limit(h_limit),
    .v_num(v_num), .v_den(v_den), .v_limit(v_limit),
    .h_newfraction(h_newfraction), .v_newfraction(v_newfraction),
    .h_ready(h_ready), .v_ready(v_ready),
    .h_step_reset(h_step_reset), .h_step_in(h_step_in),
    .v_step_reset(v_step_reset), .v_step_in(v_step_in),
    .h_step_out(h_step_out), .v_step_out(v_step_out),
    .src_pix_adv(src_pix_adv), .src_line_adv(src_line_adv),
    .running(running), .cfg_error(cfg_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_strobes();
    reconfig = 0; frame_start = 0; line_start = 0; pix_ce = 0;
    h_ready = 0; v_ready = 0; h_step_out = 0; v_step_out = 0;
  endtask

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Configuration expected while newfraction is high, from the driven dims.
  task automatic chk_cfg(input string tag);
    chk({tag, "_nf"}, {h_newfraction, v_newfraction}, 2'b11);
    chk({tag, "_h_num"}, h_num, dst_w);
    chk({tag, "_h_den"}, h_den, src_w);
    chk({tag, "_h_limit"}, h_limit, int'(src_w) - 1);
    chk({tag, "_v_num"}, v_num, dst_h);
    chk({tag, "_v_den"}, v_den, src_h);
    chk({tag, "_v_limit"}, v_limit, int'(src_h) - 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pulses"}, {running, cfg_error, h_newfraction, v_newfraction, h_step_reset,
        h_step_in, v_step_reset, v_step_in, src_pix_adv, src_line_adv}, 0);
    chk({tag, "_nums"}, {h_num, h_den, v_num, v_den}, {BW'(1), BW'(1), BW'(1), BW'(1)});
    chk({tag, "_limits"}, {h_limit, v_limit}, 0);
  endtask

  // Starting in the first WAIT cycle: pulse readies at the given WAIT offsets
  // (-1 = never) with random video strobes that must all be dropped. Reports
  // the WAIT offset at which running / cfg_error is first seen (-1 = never).
  task automatic wait_phase(input int h_at, input int v_at, output int r_at, output int e_at);
    r_at = -1; e_at = -1;
    for (int i = 0; i < 24; i++) begin
      h_ready = (i == h_at); v_ready = (i == v_at);
      frame_start = ($urandom_range(0, 3) == 0); line_start = ($urandom_range(0, 2) == 0);
      pix_ce = $urandom_range(0, 1) == 1; h_step_out = $urandom_range(0, 1) == 1;
      v_step_out = ($urandom_range(0, 3) == 0);
      tick(); clr_strobes();
      if (running) begin r_at = i + 1; break; end
      if (e_at < 0 && cfg_error) e_at = i + 1;
      chk("wait_quiet", {h_newfraction, v_newfraction, h_step_reset, h_step_in,
          v_step_reset, v_step_in, src_pix_adv, src_line_adv}, 0);
    end
  endtask

  // One RUN cycle. Reference: strobes echo one cycle later; a line_start
  // steps the vertical interpolator unless it is the first line of a frame.
  task automatic run_cycle(input logic fs, input logic ls, input logic pc, input logic hso,
                           input logic vso, input logic rc, input logic leave);
    logic exp_vsi;
    frame_start = fs; line_start = ls; pix_ce = pc;
    h_step_out = hso; v_step_out = vso; reconfig = rc;
    exp_vsi = 1'b0;
    if (fs) lines_in_frame = 0;
    if (ls) begin exp_vsi = (lines_in_frame > 0); lines_in_frame++; end
    tick(); clr_strobes();
    chk("run_strobes", {v_step_reset, h_step_reset, v_step_in, h_step_in, src_pix_adv,
        src_line_adv, running}, {fs, ls, exp_vsi, pc, hso, vso, ~leave});
    t_vsr += int'(v_step_reset); t_hsr += int'(h_step_reset); t_vsi += int'(v_step_in);
    t_hsi += int'(h_step_in); t_pix += int'(src_pix_adv); t_line += int'(src_line_adv);
  endtask

  task automatic clr_tally();
    t_vsr = 0; t_hsr = 0; t_vsi = 0; t_hsi = 0; t_pix = 0; t_line = 0;
  endtask

  initial begin
    src_w = 320; src_h = 240; dst_w = 640; dst_h = 480;
    clr_strobes(); clr_tally();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");

    // Upscale 320x240 -> 640x480
    reset_n = 1;
    tick();
    chk("check_nf", {h_newfraction, v_newfraction, running}, 0);
    tick();
    chk_cfg("up");
    chk("up_h_num_const", h_num, 640);
    chk("up_h_limit_const", h_limit, 319);
    chk("up_v_limit_const", v_limit, 239);
    tick();
    chk("wait_nf_low", {h_newfraction, v_newfraction}, 0);
    wait_phase(5, 9, run_at, err_at);
    chk("up_run_at", run_at, 10);
    chk("up_cfg_error", cfg_error, 0);

    // Line sequencing
    clr_tally();
    run_cycle(1, 0, 0, 0, 0, 0, 0);
    for (int l = 0; l < 3; l++) begin
      run_cycle(0, 1, 0, 0, 0, 0, 0);
      for (int p = 0; p < 4; p++) run_cycle(0, 0, 1, 0, 0, 0, 0);
    end
    chk("seq_v_step_reset", t_vsr, 1);
    chk("seq_h_step_reset", t_hsr, 3);
    chk("seq_v_step_in", t_vsi, 2);
    chk("seq_h_step_in", t_hsi, 12);

    // Simultaneous frame/line start, step_out pass-through
    clr_tally();
    run_cycle(1, 1, 0, 1, 0, 0, 0);
    run_cycle(0, 1, 1, 1, 0, 0, 0);
    run_cycle(0, 0, 0, 1, 1, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0);
    chk("sim_v_step_reset", t_vsr, 1);
    chk("sim_h_step_reset", t_hsr, 2);
    chk("sim_v_step_in", t_vsi, 1);
    chk("sim_src_pix_adv", t_pix, 3);
    chk("sim_src_line_adv", t_line, 1);

    // Random RUN traffic
    run_cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++)
      run_cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, 1'b0, 1'b0);

    // reconfig together with strobes: strobes forwarded, then leave RUN
    run_cycle(0, 1, 1, 1, 0, 1, 1);
    tick();
    chk_cfg("reconfig");
    tick();
    wait_phase(0, 0, run_at, err_at);
    chk("reconfig_run_at", run_at, 1);

    // Random upscale configurations via dimension changes in RUN
    for (int k = 0; k < 3; k++) begin
      src_w = BW'($urandom_range(1, 400)); dst_w = BW'($urandom_range(int'(src_w), 1023));
      src_h = BW'($urandom_range(1, 400)); dst_h = BW'($urandom_range(int'(src_h), 1023));
      run_cycle(0, 0, 0, 0, 0, 0, 1);
      tick();
      chk_cfg("rand_cfg");
      tick();
      ha = $urandom_range(0, 12); va = $urandom_range(0, 12);
      wait_phase(ha, va, run_at, err_at);
      chk("rand_run_at", run_at, imax(ha, va) + 1);
    end

    // Downscale rejected, then recovery
    held_num = dst_w;
    src_w = 320; src_h = 240; dst_w = 200; dst_h = 480;
    run_cycle(0, 0, 0, 0, 0, 0, 1);
    chk("down_check_nf", {h_newfraction, v_newfraction}, 0);
    tick();
    chk("down_err", {cfg_error, running, h_newfraction}, 3'b100);
    chk("down_h_num_held", h_num, held_num);
    wait_phase(-1, -1, run_at, err_at);
    chk("down_stays_err", {run_at != -1, cfg_error}, 2'b01);
    dst_w = 640;
    tick();
    chk("recov_check_err", {cfg_error, h_newfraction}, 2'b10);
    h_ready = 1; v_ready = 1;
    tick();
    clr_strobes();
    chk_cfg("recov");
    chk("recov_load_err", cfg_error, 1);
    tick();
    wait_phase(2, 4, run_at, err_at);
    chk("recov_run_at", run_at, 5);
    chk("recov_err_clear", cfg_error, 0);

    // Timeout: v_ready never arrives
    run_cycle(0, 0, 0, 0, 0, 1, 1);
    tick();
    chk_cfg("to");
    tick();
    wait_phase(3, -1, run_at, err_at);
    chk("to_err_at", err_at, TO);
    chk("to_no_run", run_at, -1);

    // Reset in the middle of WAIT
    reconfig = 1;
    tick();
    clr_strobes();
    tick();
    chk_cfg("mid");
    tick(); tick(); tick();
    chk("mid_wait", {running, cfg_error}, 2'b01);
    reset_n = 0;
    #1;
    chk_reset_vals("mid_reset");
    tick();
    reset_n = 1;
    tick();
    chk("mid_check_nf", {h_newfraction, v_newfraction}, 0);
    tick();
    chk_cfg("mid_reload");
    tick();
    wait_phase(3, 3, run_at, err_at);
    chk("mid_run_at", run_at, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scaler_sequencer.md
# scaler_sequencer

Controller for the scandoubler's scaling path. It configures and sequences one horizontal and one vertical `frac_interp` instance. From the source and destination dimensions it loads both interpolators, waits for their dividers to finish, then converts output video timing strobes into `step_reset` and `step_in` pulses. It also turns the interpolators' `step_out` pulses into source-pixel and source-line advance strobes for the line-buffer fetch logic.

## Interface

Parameters:
- `bitwidth`, default 10: width of all dimension and count values.
- `timeout`, default 1023: maximum cycles to wait for each interpolator's ready pulse after `newfraction`.

Ports:
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `src_w`, `src_h`, in, bitwidth each: source active width and height.
- `dst_w`, `dst_h`, in, bitwidth each: destination active width and height.
- `reconfig`, in, 1: one-cycle strobe that forces reconfiguration.
- `frame_start`, in, 1: output frame start strobe.
- `line_start`, in, 1: output active-line start strobe.
- `pix_ce`, in, 1: output active-pixel enable.
- `h_num`, `h_den`, `h_limit`, out, bitwidth each: horizontal interpolator configuration.
- `v_num`, `v_den`, `v_limit`, out, bitwidth each: vertical interpolator configuration.
- `h_newfraction`, `v_newfraction`, out, 1: divider start pulses.
- `h_ready`, `v_ready`, in, 1: interpolator ready pulses.
- `h_step_reset`, `h_step_in`, out, 1: horizontal sequencing strobes.
- `v_step_reset`, `v_step_in`, out, 1: vertical sequencing strobes.
- `h_step_out`, `v_step_out`, in, 1: interpolator advance pulses.
- `src_pix_adv`, `src_line_adv`, out, 1: source fetch strobes.
- `running`, out, 1: high in the RUN state.
- `cfg_error`, out, 1: sticky error flag; cleared only on a successful configuration.

## Operation

State machine: IDLE → CHECK → LOAD → WAIT → RUN; ERROR is a side state.

- **IDLE:** entered on reset. Moves to CHECK on the next cycle.
- **CHECK:** latches `src_*` and `dst_*` into shadow registers.
  - Any dimension equal to 0, `dst_w<src_w`, or `dst_h<src_h` (downscaling is not supported) → ERROR.
  - Otherwise → LOAD.
- **LOAD:**
  - Drives `h_num=dst_w`, `h_den=src_w`, `h_limit=src_w-1`, and the same mapping for `v_*` from the shadow registers.
  - Outputs are registered and held stable until the next CHECK.
  - Pulses `h_newfraction` and `v_newfraction` high for exactly one cycle, together.
  - Clears the sticky flags `h_ok` and `v_ok`, loads the timeout counter, → WAIT.
- **WAIT:**
  - `h_ready` and `v_ready` are single-cycle pulses, not levels. Each one sets its sticky flag, so the two may arrive in any order or in the same cycle.
  - When both flags are set → RUN, and `cfg_error` clears.
  - The counter decrements every cycle. On reaching 0 with either flag clear → ERROR.
- **RUN:** `running`=1. Strobe generation:
  - `frame_start` → `v_step_reset`=1 and sets `first_line`.
  - `line_start` → `h_step_reset`=1. It also gives `v_step_in`=1 unless `first_line` is set; in that case `first_line` clears and no `v_step_in` is issued.
  - `pix_ce` → `h_step_in`=1.
  - `h_step_out` → `src_pix_adv`; `v_step_out` → `src_line_adv`.
- **ERROR:** `cfg_error`=1, all step and newfraction outputs are 0, `running`=0.
- **Change detection:** in RUN or ERROR, a `reconfig` pulse or any mismatch between the inputs and the shadow registers → CHECK on the next cycle. `running` drops the same cycle CHECK is entered.
- **Strobes outside RUN:** strobes received in IDLE, CHECK, LOAD, WAIT, or ERROR are dropped.
- **Simultaneous events:**
  - `frame_start` and `line_start` in the same cycle: both resets are issued, and that line is treated as the first line (no `v_step_in`).
  - `reconfig` in the same cycle as strobes: the strobes are still forwarded that cycle, then the block leaves RUN.

## Timing

- **Reset values:** every output is 0, except `h_num`/`h_den`/`v_num`/`v_den`, which reset to 1, and `h_limit`/`v_limit`, which reset to 0.
- **Step strobes:** all step outputs are registered and appear 1 cycle after their input strobe.
- **Fetch strobes:** `src_pix_adv` and `src_line_adv` are registered, with 1 cycle of latency from `step_out`.
- **Configuration latency:** CHECK is 1 cycle and LOAD is 1 cycle. `newfraction` asserts in the cycle after CHECK. Configuration values are valid in the same cycle as `newfraction` and stay stable afterwards.
- **Ready handshake:**
  - `h_ready` and `v_ready` are ignored in the cycle `newfraction` is high.
  - They are sampled in every WAIT cycle.
  - RUN is entered the cycle after the second flag is set.
- **Timeout:** exactly `timeout` WAIT cycles without both flags → ERROR on the following cycle.
- **Mid-operation reset:** asynchronous reset forces IDLE immediately. All pulses abort and the shadow registers clear to 0.

## Test plan

- **Upscale config:** `src` 320×240, `dst` 640×480, reset release, `h_ready` at WAIT+5, `v_ready` at WAIT+9 → `h_num`=640, `h_den`=320, `h_limit`=319, `v_limit`=239; one `newfraction` pulse; `running` rises at WAIT+10.
- **Downscale rejected:** `dst_w`=200 with `src_w`=320 → ERROR, `cfg_error`=1, no `newfraction` pulse. Then setting `dst_w`=640 → reconfiguration, and `cfg_error` clears on reaching RUN.
- **Timeout:** `v_ready` never pulses, `timeout`=16 → ERROR after 16 WAIT cycles, step outputs stay 0.
- **Line sequencing:** in RUN, `frame_start`, then 3 `line_start`s each followed by 4 `pix_ce` → 1 `v_step_reset`, 3 `h_step_reset`, 2 `v_step_in`, 12 `h_step_in`, each delayed 1 cycle.
- **Simultaneous start strobes:** `frame_start` and `line_start` in the same cycle → both resets issued, no `v_step_in`. `h_step_out` pulses are passed to `src_pix_adv` 1:1.
- **Reset mid-WAIT:** `reset_n`=0 during WAIT → all outputs return to reset values immediately. After release, the full CHECK/LOAD sequence repeats.
